// File: rtl/subleq_pkg.sv
// Shared constants for the SUBLEQ sequencer: state encoding, default width,
// and ALU mode encodings.
package subleq_pkg;

  localparam int DW_DEFAULT = 16;

  localparam logic ALU_MODE_SUB = 1'b1;  // B - A
  localparam logic ALU_MODE_INC = 1'b0;  // A + 1

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH_A  = 4'd1,
    S_FETCH_B  = 4'd2,
    S_FETCH_C  = 4'd3,
    S_READ_A   = 4'd4,
    S_READ_B   = 4'd5,
    S_ALU_LD   = 4'd6,
    S_ALU_LDB  = 4'd7,
    S_ALU_WAIT = 4'd8,
    S_WRITE    = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_e;

endpackage

// File: rtl/subleq_mem_port.sv
// Memory req/ack holder. The FSM registers the address/data/we and a one-cycle
// start strobe on the state-entry edge, so the request is visible in the entry
// cycle; this block keeps it up until ack and returns a registered done pulse
// one cycle after the ack, which also yields the mandatory idle gap.
module subleq_mem_port import subleq_pkg::*; #(
  parameter int DATAWIDTH = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 we_i,
  input  logic [DATAWIDTH-1:0] addr_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  input  logic [DATAWIDTH-1:0] mem_rdata_i,
  input  logic                 mem_ack_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [DATAWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  output logic                 done_o,
  output logic [DATAWIDTH-1:0] rdata_o
);

  logic                 pend_q;
  logic                 done_q;
  logic [DATAWIDTH-1:0] rdata_q;

  assign mem_req_o   = start_i | pend_q;
  assign mem_we_o    = we_i;
  assign mem_addr_o  = addr_i;
  assign mem_wdata_o = wdata_i;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;

  // Hold the request until ack; capture read data and pulse done afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      pend_q <= mem_req_o & ~mem_ack_i;
      done_q <= mem_req_o & mem_ack_i;
      if (mem_req_o && mem_ack_i) rdata_q <= mem_rdata_i;
    end
  end

endmodule

// File: rtl/subleq_sequencer.sv
// SUBLEQ control FSM: fetch A/B/C, read mem[A]/mem[B], load the ALU, wait for
// B-A, write it back to mem[B] and branch on the registered LEZ flag.
module subleq_sequencer import subleq_pkg::*; #(
  parameter int                   DATAWIDTH = DW_DEFAULT,
  parameter logic [DATAWIDTH-1:0] HALT_ADDR = {DATAWIDTH{1'b1}},
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 alu_ld_a,
  output logic                 alu_ld_b,
  output logic                 alu_mode,
  output logic [DATAWIDTH-1:0] alu_src,
  input  logic [DATAWIDTH-1:0] alu_result,
  input  logic                 alu_done,
  input  logic                 alu_lez,
  output logic [DATAWIDTH-1:0] pc,
  output logic                 halted,
  output logic                 busy
);

  state_e               state_q;
  logic [DATAWIDTH-1:0] pc_q, opa_q, opb_q, opc_q, vala_q, valb_q;
  logic [DATAWIDTH-1:0] src_q, maddr_q, mwdata_q;
  logic                 mstart_q, mwe_q, ld_a_q, ld_b_q, lez_q, wait_q;
  logic                 halted_q, busy_q;
  logic                 mdone;
  logic [DATAWIDTH-1:0] mrdata;
  logic [DATAWIDTH-1:0] pc_br;

  // Target of the branch cycle; the +3 wraps naturally at DATAWIDTH bits.
  assign pc_br = lez_q ? opc_q : pc_q + DATAWIDTH'(3);

  assign alu_ld_a = ld_a_q;
  assign alu_ld_b = ld_b_q;
  assign alu_mode = ALU_MODE_SUB;
  assign alu_src  = src_q;
  assign pc       = pc_q;
  assign halted   = halted_q;
  assign busy     = busy_q;

  subleq_mem_port #(.DATAWIDTH(DATAWIDTH)) u_mem (
    .clk         (clk),
    .rst         (rst),
    .start_i     (mstart_q),
    .we_i        (mwe_q),
    .addr_i      (maddr_q),
    .wdata_i     (mwdata_q),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .done_o      (mdone),
    .rdata_o     (mrdata)
  );

  // Instruction sequencer; every memory state is entered together with a
  // start strobe so the request appears in the entry cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      opa_q    <= '0;
      opb_q    <= '0;
      opc_q    <= '0;
      vala_q   <= '0;
      valb_q   <= '0;
      src_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mstart_q <= 1'b0;
      mwe_q    <= 1'b0;
      ld_a_q   <= 1'b0;
      ld_b_q   <= 1'b0;
      lez_q    <= 1'b0;
      wait_q   <= 1'b0;
      halted_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      mstart_q <= 1'b0;
      ld_a_q   <= 1'b0;
      ld_b_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (run) begin
          state_q  <= S_FETCH_A;
          busy_q   <= 1'b1;
          mstart_q <= 1'b1;
          mwe_q    <= 1'b0;
          maddr_q  <= pc_q;
        end
        S_FETCH_A: if (mdone) begin
          opa_q    <= mrdata;
          state_q  <= S_FETCH_B;
          mstart_q <= 1'b1;
          maddr_q  <= pc_q + DATAWIDTH'(1);
        end
        S_FETCH_B: if (mdone) begin
          opb_q    <= mrdata;
          state_q  <= S_FETCH_C;
          mstart_q <= 1'b1;
          maddr_q  <= pc_q + DATAWIDTH'(2);
        end
        S_FETCH_C: if (mdone) begin
          opc_q    <= mrdata;
          state_q  <= S_READ_A;
          mstart_q <= 1'b1;
          maddr_q  <= opa_q;
        end
        S_READ_A: if (mdone) begin
          vala_q   <= mrdata;
          state_q  <= S_READ_B;
          mstart_q <= 1'b1;
          maddr_q  <= opb_q;
        end
        S_READ_B: if (mdone) begin
          valb_q  <= mrdata;
          state_q <= S_ALU_LD;
          ld_a_q  <= 1'b1;
          src_q   <= vala_q;
        end
        S_ALU_LD: begin
          state_q <= S_ALU_LDB;
          ld_b_q  <= 1'b1;
          src_q   <= valb_q;
        end
        S_ALU_LDB: begin
          state_q <= S_ALU_WAIT;
          wait_q  <= 1'b0;
        end
        // done may still be stale in the first wait cycle; trust it from the second.
        S_ALU_WAIT: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else if (alu_done) begin
            lez_q    <= alu_lez;
            mwdata_q <= alu_result;
            maddr_q  <= opb_q;
            mwe_q    <= 1'b1;
            mstart_q <= 1'b1;
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: if (mdone) state_q <= S_BRANCH;
        S_BRANCH: begin
          if (lez_q && opc_q == HALT_ADDR) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            pc_q <= pc_br;
            if (run) begin
              state_q  <= S_FETCH_A;
              mstart_q <= 1'b1;
              mwe_q    <= 1'b0;
              maddr_q  <= pc_br;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_HALT: state_q <= S_HALT;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Bench for subleq_sequencer: behavioural memory and ALU, a table of single
// instructions, hand-written corner sequences and a randomized run checked
// against a plain SUBLEQ interpreter.
module tb_subleq_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        alu_ld_a, alu_ld_b, alu_mode, alu_done, alu_lez;
  logic [15:0] alu_src, alu_result, pc;
  logic        halted, busy;

  always #5 clk = ~clk;

  subleq_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_ld_a(alu_ld_a), .alu_ld_b(alu_ld_b), .alu_mode(alu_mode),
    .alu_src(alu_src), .alu_result(alu_result), .alu_done(alu_done),
    .alu_lez(alu_lez), .pc(pc), .halted(halted), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Memory: combinational ack after a programmable number of wait cycles.
  logic [15:0] tmem [0:65535];
  int unsigned cnt = 0, fix_d = 0, rnd_d = 0;
  bit          rnd_mode = 1'b0;
  assign mem_ack   = mem_req && (cnt >= (rnd_mode ? rnd_d : fix_d));
  assign mem_rdata = tmem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      cnt <= 0;
      if (mem_we) tmem[mem_addr] <= mem_wdata;
      rnd_d <= $urandom_range(0, 3);
    end else if (mem_req) cnt <= cnt + 1;
    else cnt <= 0;
  end

  // ALU: done drops on a load edge and returns one cycle later.
  logic [15:0] ra = 16'h0, rb = 16'h0;
  logic        done_r = 1'b0, pend = 1'b0;
  assign alu_result = alu_mode ? rb - ra : ra + 16'd1;
  assign alu_lez    = alu_result[15] | (alu_result == 16'd0);
  assign alu_done   = done_r;

  always @(posedge clk) begin
    if (alu_ld_a) ra <= alu_src;
    if (alu_ld_b) rb <= alu_src;
    if (alu_ld_a || alu_ld_b) begin
      done_r <= 1'b0;
      pend   <= 1'b1;
    end else if (pend) begin
      done_r <= 1'b1;
      pend   <= 1'b0;
    end
  end

  // Reference SUBLEQ interpreter.
  logic [15:0] rmem [0:65535];
  logic [15:0] rpc = 16'h0;
  bit          rhalt = 1'b0;

  task automatic model_step(output logic [15:0] wa, output logic [15:0] wd);
    logic [15:0] p1, p2, a, b, c, r;
    p1 = rpc + 16'd1;
    p2 = rpc + 16'd2;
    a = rmem[rpc];
    b = rmem[p1];
    c = rmem[p2];
    r = rmem[b] - rmem[a];
    rmem[b] = r;
    wa = b;
    wd = r;
    if ($signed(r) <= 0) begin
      if (c == 16'hFFFF) rhalt = 1'b1;
      else rpc = c;
    end else rpc = rpc + 16'd3;
  endtask

  // Protocol monitors and write checking against the model.
  logic        p_req = 1'b0, p_ack = 1'b0, p_lda = 1'b0, p_ldb = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = 16'h0, p_wd = 16'h0;
  logic [15:0] rdq [$];
  int          nwr = 0;
  bit          model_on = 1'b0;

  always @(negedge clk) begin
    logic [15:0] wa, wd;
    if (!rst) begin
      if (p_req && !p_ack && mem_req)
        chk("mem_hold", {31'd0, mem_we, mem_addr, mem_wdata}, {31'd0, p_we, p_addr, p_wd});
      if (p_req && p_ack) chk("mem_gap", 64'(mem_req), 64'd0);
      if (alu_ld_a) chk("ld_a_width", 64'(p_lda), 64'd0);
      if (alu_ld_b) chk("ld_b_width", 64'(p_ldb), 64'd0);
      if (alu_ld_a || alu_ld_b) chk("alu_mode", 64'(alu_mode), 64'd1);
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          nwr++;
          if (model_on) begin
            model_step(wa, wd);
            chk("rand_wr_addr", 64'(mem_addr), 64'(wa));
            chk("rand_wr_data", 64'(mem_wdata), 64'(wd));
          end
        end else rdq.push_back(mem_addr);
      end
    end
    p_req  <= mem_req;
    p_ack  <= mem_ack;
    p_we   <= mem_we;
    p_addr <= mem_addr;
    p_wd   <= mem_wdata;
    p_lda  <= alu_ld_a;
    p_ldb  <= alu_ld_b;
  end

  typedef struct {
    logic [15:0] a, b, c, va, vb;
    int          dly;
    logic [15:0] wd, epc;
    logic        hlt;
    int          cyc;
  } vec_t;

  vec_t tbl [7];

  task automatic pulse_reset();
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, cyc, nreq, bad;

    tbl[0] = '{16'd3, 16'd4, 16'd6,      16'd5,    16'd7,    0, 16'd2,    16'd3,  1'b0, 17};
    tbl[1] = '{16'd3, 16'd4, 16'd9,      16'd7,    16'd5,    0, 16'hFFFE, 16'd9,  1'b0, 17};
    tbl[2] = '{16'd3, 16'd3, 16'hFFFF,   16'd42,   16'd42,   0, 16'd0,    16'd0,  1'b1, 17};
    tbl[3] = '{16'd3, 16'd4, 16'd6,      16'd5,    16'd7,    5, 16'd2,    16'd3,  1'b0, 47};
    tbl[4] = '{16'd5, 16'd6, 16'd12,     16'd9,    16'd9,    0, 16'd0,    16'd12, 1'b0, 17};
    tbl[5] = '{16'd3, 16'd4, 16'd6,      16'h8000, 16'd1,    0, 16'h8001, 16'd6,  1'b0, 17};
    tbl[6] = '{16'd3, 16'd4, 16'd6,      16'd1,    16'h8000, 2, 16'h7FFF, 16'd3,  1'b0, 29};

    for (int i = 0; i < 65536; i++) tmem[i] = 16'h0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({mem_req, mem_we, alu_ld_a, alu_ld_b, alu_mode, halted, busy}), 64'b0000100);
    chk("reset_data", {mem_addr, mem_wdata, alu_src, pc}, 64'd0);
    rst = 1'b0;

    // Single-instruction vectors
    for (int k = 0; k < 7; k++) begin
      pulse_reset();
      for (int i = 0; i < 16; i++) tmem[i] = 16'h0;
      tmem[0] = tbl[k].a;
      tmem[1] = tbl[k].b;
      tmem[2] = tbl[k].c;
      tmem[tbl[k].a] = tbl[k].va;
      tmem[tbl[k].b] = tbl[k].vb;
      fix_d = tbl[k].dly;
      rnd_mode = 1'b0;
      nwr = 0;
      run = 1'b1;
      n = 0;
      while (!busy && n < 10) begin @(negedge clk); n++; end
      run = 1'b0;
      cyc = 0;
      while (busy && cyc < 400) begin cyc++; @(negedge clk); end
      chk($sformatf("v%0d_cycles", k), 64'(cyc), 64'(tbl[k].cyc));
      chk($sformatf("v%0d_pc", k), 64'(pc), 64'(tbl[k].epc));
      chk($sformatf("v%0d_halted", k), 64'(halted), 64'(tbl[k].hlt));
      chk($sformatf("v%0d_mem", k), 64'(tmem[tbl[k].b]), 64'(tbl[k].wd));
      chk($sformatf("v%0d_nwr", k), 64'(nwr), 64'd1);
      if (tbl[k].hlt) begin
        run = 1'b1;
        nreq = 0;
        repeat (50) begin @(negedge clk); if (mem_req) nreq++; end
        chk("halt_quiet", 64'(nreq), 64'd0);
        chk("halt_hold", 64'({halted, busy}), 64'b10);
        run = 1'b0;
      end
    end

    // Reset during the second instruction's write, with the ack held off
    pulse_reset();
    for (int i = 0; i < 16; i++) tmem[i] = 16'h0;
    tmem[0] = 16'd3; tmem[1] = 16'd4; tmem[2] = 16'd6;
    tmem[3] = 16'd5; tmem[4] = 16'd7;
    fix_d = 8;
    run = 1'b1;
    n = 0;
    while (!(mem_req && mem_we && mem_addr == 16'd2) && n < 1000) begin @(negedge clk); n++; end
    chk("rstw_reached", 64'(n < 1000), 64'd1);
    chk("rstw_pc_pre", 64'(pc), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_ctl", 64'({mem_req, busy, halted}), 64'd0);
    chk("rstw_pc", 64'(pc), 64'd0);
    rst = 1'b0;
    run = 1'b0;
    repeat (12) @(negedge clk);
    chk("rstw_idle", 64'({mem_req, busy}), 64'd0);
    chk("rstw_nowrite", 64'(tmem[2]), 64'd6);

    // Address wrap: jump to 0xFFFE, then drop run during READ_B
    pulse_reset();
    for (int i = 0; i < 65536; i++) tmem[i] = 16'h0;
    tmem[0] = 16'd10; tmem[1] = 16'd10; tmem[2] = 16'hFFFE;
    tmem[10] = 16'd4;
    tmem[16'hFFFE] = 16'd20; tmem[16'hFFFF] = 16'd21;
    tmem[20] = 16'd3; tmem[21] = 16'd8;
    fix_d = 0;
    rdq.delete();
    run = 1'b1;
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 16'd21) && n < 200) begin @(negedge clk); n++; end
    chk("wrap_reached", 64'(n < 200), 64'd1);
    run = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (rdq.size() >= 8) begin
      chk("wrap_fetch0", 64'(rdq[5]), 64'hFFFE);
      chk("wrap_fetch1", 64'(rdq[6]), 64'hFFFF);
      chk("wrap_fetch2", 64'(rdq[7]), 64'h0000);
    end else chk("wrap_nreads", 64'(rdq.size()), 64'd8);
    chk("wrap_pc", 64'(pc), 64'd1);
    chk("wrap_mem", 64'(tmem[21]), 64'd5);
    repeat (5) @(negedge clk);
    chk("wrap_idle", 64'({mem_req, busy, halted}), 64'd0);

    // Randomized programs against the interpreter
    for (int r = 0; r < 3; r++) begin
      rst = 1'b1;
      run = 1'b0;
      for (int i = 0; i < 65536; i++) begin tmem[i] = 16'h0; rmem[i] = 16'h0; end
      for (int i = 0; i < 32; i++) begin
        tmem[i] = 16'($urandom_range(0, 31));
        rmem[i] = tmem[i];
      end
      rpc = 16'h0;
      rhalt = 1'b0;
      rnd_mode = 1'b1;
      nwr = 0;
      @(negedge clk);
      rst = 1'b0;
      model_on = 1'b1;
      run = 1'b1;
      n = 0;
      while (nwr < 40 && !halted && n < 20000) begin @(negedge clk); n++; end
      run = 1'b0;
      n = 0;
      while (busy && n < 500) begin @(negedge clk); n++; end
      model_on = 1'b0;
      chk("rand_idle", 64'(busy), 64'd0);
      chk("rand_pc", 64'(pc), 64'(rpc));
      chk("rand_halted", 64'(halted), 64'(rhalt));
      bad = 0;
      for (int i = 0; i < 64; i++) if (tmem[i] !== rmem[i]) bad++;
      chk("rand_memimg", 64'(bad), 64'd0);
    end
    rnd_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/subleq_sequencer.md
Name: subleq_sequencer

Overview:
- Control FSM that executes one SUBLEQ instruction (mem[B] = mem[B] - mem[A]; if result <= 0 jump to C, else PC += 3) per pass.
- Fetches the three operand words through a req/ack memory port.
- Drives the subtract/increment ALU through load strobes and waits on its done flag; the ALU's LEZ flag selects the branch.
- Sits between the memory card and the ALU card as the sole master of both.

Parameters:
- DATAWIDTH, 16, width of data words, addresses and PC.
- HALT_ADDR, {DATAWIDTH{1'b1}}, branch target that halts the machine instead of jumping.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- run  input  1  level; while high, instructions execute back-to-back; low stops at the next FETCH_A boundary.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  output  DATAWIDTH  memory address; stable while mem_req is high.
- mem_wdata  output  DATAWIDTH  write data; stable while mem_req and mem_we are high.
- mem_rdata  input  DATAWIDTH  read data; valid in the mem_ack cycle.
- mem_ack  input  1  one-cycle completion pulse.
- alu_ld_a  output  1  one-cycle strobe: ALU A <= alu_src.
- alu_ld_b  output  1  one-cycle strobe: ALU B <= alu_src.
- alu_mode  output  1  1 = B-A, 0 = A+1; constant for the whole instruction at 1.
- alu_src  output  DATAWIDTH  operand driven to the ALU.
- alu_result  input  DATAWIDTH  ALU result.
- alu_done  input  1  result valid (clean).
- alu_lez  input  1  result sign bit set or result zero.
- pc  output  DATAWIDTH  current program counter.
- halted  output  1  high in HALT.
- busy  output  1  high in any state other than IDLE or HALT.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, alu_ld_a=0, alu_ld_b=0, alu_mode=1, alu_src=0, halted=0, busy=0. Reset overrides everything, including mid-transaction; an outstanding mem_ack after reset is ignored.
- Internal registers: opA, opB, opC (addresses), valA, valB (data); all cleared on reset.
- States:
  - IDLE: run=1 -> FETCH_A.
  - FETCH_A / FETCH_B / FETCH_C: read at pc, pc+1, pc+2 respectively (mod 2^DATAWIDTH); on mem_ack latch opA / opB / opC.
  - READ_A: read at opA -> valA.
  - READ_B: read at opB -> valB.
  - ALU_LD: one cycle; alu_src=valA, alu_ld_a=1.
  - ALU_LDB: one cycle; alu_src=valB, alu_ld_b=1.
  - ALU_WAIT: waits for alu_done=1, sampled no earlier than the 2nd cycle after ALU_LDB, because done drops only after the load edge.
  - WRITE: mem_we=1, addr=opB, wdata=alu_result captured on ALU_WAIT exit.
  - BRANCH: one cycle.
    - If lez and opC==HALT_ADDR -> HALT.
    - Else if lez -> pc=opC.
    - Else pc=pc+3 (wraps).
    - Then -> FETCH_A if run, else IDLE.
  - HALT: terminal until rst.
- Memory handshake:
  - mem_req asserts on the state-entry cycle and deasserts the cycle after ack.
  - Address and data are held constant throughout the request.
  - Back-to-back requests have at least one idle cycle between them.
  - Any wait length is legal; there is no timeout.
- Latency: with 1-cycle ack memory and a 1-cycle ALU, one instruction takes 6 memory transactions (2 cycles each), plus 2 load cycles, 2 wait cycles and 1 branch cycle = 17 cycles.
- Arithmetic: all address increments wrap modulo 2^DATAWIDTH (pc=0xFFFE -> operands at 0xFFFE, 0xFFFF, 0x0000).
- Simultaneous events: run falling mid-instruction completes the instruction. lez is sampled only in the ALU_WAIT exit cycle and registered for BRANCH.
- Self-modifying code: A==B is legal (result 0, branch taken). A write to the instruction's own words takes effect on the next fetch.

Decomposition:
- Shared package/include: state encoding constants (4-bit), the DATAWIDTH default, and ALU mode constants (ALU_MODE_SUB=1, ALU_MODE_INC=0).
- One sub-module is natural: subleq_mem_port, the req/ack handshake holder (start strobe, addr/wdata/we in; done pulse and rdata out). The FSM instantiates it once.

Test Plan:
- Reset mid-WRITE (mem_req high): assert rst -> next cycle state=IDLE, pc=0, mem_req=0, busy=0.
- mem: 0:{3,4,6} 3:5 4:7, run=1 -> write mem[4]=2; lez=0; pc=3.
- mem: 0:{3,4,9} 3:7 4:5 -> mem[4]=0xFFFE; lez=1; pc=9.
- Halt: 0:{3,3,0xFFFF} 3:42 -> mem[3]=0; halted=1, busy=0, no further mem_req for 50 cycles.
- mem_ack delayed 5 cycles on each transaction -> mem_addr stable across every wait; result identical to the non-delayed case; alu_ld strobes exactly one cycle each.
- Wrap: RESET_PC=0xFFFE, run -> fetch addresses 0xFFFE, 0xFFFF, 0x0000; not-taken branch gives pc=0x0001. Drop run mid-READ_B -> instruction completes, then IDLE.
